axi_master: RTL

//  Single-outstanding AXI initiator driving the axi_slave port set (AW/W/B/AR/R, 1-bit BRESP/RRESP).

---
 rtl/axi_pkg.sv | 22 ++
 rtl/axi_addr_gen.sv | 33 +++
 rtl/axi_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI initiator: burst encodings, FSM states, AxSIZE decode.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5
  } state_t;

  // Bytes per beat for an AxSIZE encoding (1..128).
  function automatic logic [7:0] axsize_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; reserved burst code 11 behaves as INCR.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;

  always_comb begin
    step       = ADDR_W'(axsize_bytes(size));
    // WRAP window is beats*bytes, always a power of two for legal lengths
    wrap_bytes = step * (ADDR_W'(len) + ADDR_W'(1));
    wrap_mask  = wrap_bytes - ADDR_W'(1);
    incr_addr  = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_master.sv
// Single-outstanding AXI initiator: one burst command at a time, writes and reads serialised.
module axi_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              done,
  output logic              done_resp,
  output logic              len_err,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  output logic              WLAST,
  input  logic              WREADY,
  input  logic              BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  state_t            state_reg;
  logic              cmd_ready_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] cur_addr_reg;
  logic [ADDR_W-1:0] cur_addr_next;
  logic [7:0]        len_reg;
  logic [2:0]        size_reg;
  logic [1:0]        burst_reg;
  logic [7:0]        beat_cnt_reg;
  logic              awvalid_reg;
  logic              arvalid_reg;
  logic              bready_reg;
  logic              rready_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_data_valid_reg;
  logic              done_reg;
  logic              done_resp_reg;
  logic              len_err_reg;
  logic              last_beat;
  logic              w_fire;

  // Beat address is tracked for debug only; the bus carries just the start address.
  axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (cur_addr_reg),
    .len       (len_reg),
    .size      (size_reg),
    .burst     (burst_reg),
    .next_addr (cur_addr_next)
  );

  assign last_beat = (beat_cnt_reg == len_reg);
  assign WVALID    = (state_reg == ST_W) && wr_data_valid;
  assign WDATA     = (state_reg == ST_W) ? wr_data : '0;
  assign WLAST     = (state_reg == ST_W) && last_beat;
  assign w_fire    = WVALID && WREADY;

  assign wr_data_ready = w_fire;
  assign cmd_ready     = cmd_ready_reg;
  assign rd_data       = rd_data_reg;
  assign rd_data_valid = rd_data_valid_reg;
  assign done          = done_reg;
  assign done_resp     = done_resp_reg;
  assign len_err       = len_err_reg;
  assign AWADDR        = addr_reg;
  assign AWLEN         = len_reg;
  assign AWSIZE        = size_reg;
  assign AWBURST       = burst_reg;
  assign AWVALID       = awvalid_reg;
  assign ARADDR        = addr_reg;
  assign ARLEN         = len_reg;
  assign ARSIZE        = size_reg;
  assign ARBURST       = burst_reg;
  assign ARVALID       = arvalid_reg;
  assign BREADY        = bready_reg;
  assign RREADY        = rready_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cmd_ready_reg     <= 1'b0;
      addr_reg          <= '0;
      cur_addr_reg      <= '0;
      len_reg           <= '0;
      size_reg          <= '0;
      burst_reg         <= '0;
      beat_cnt_reg      <= '0;
      awvalid_reg       <= 1'b0;
      arvalid_reg       <= 1'b0;
      bready_reg        <= 1'b0;
      rready_reg        <= 1'b0;
      rd_data_reg       <= '0;
      rd_data_valid_reg <= 1'b0;
      done_reg          <= 1'b0;
      done_resp_reg     <= 1'b0;
      len_err_reg       <= 1'b0;
    end else begin
      done_reg          <= 1'b0;
      rd_data_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // cmd_ready comes up one cycle after entry, so done never coincides with an accept
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            addr_reg      <= cmd_addr;
            cur_addr_reg  <= cmd_addr;
            len_reg       <= cmd_len;
            size_reg      <= cmd_size;
            burst_reg     <= cmd_burst;
            beat_cnt_reg  <= '0;
            len_err_reg   <= 1'b0;
            if (cmd_write) begin
              awvalid_reg <= 1'b1;
              state_reg   <= ST_AW;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_AR;
            end
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end
        ST_AW: begin
          if (awvalid_reg && AWREADY) begin
            awvalid_reg <= 1'b0;
            state_reg   <= ST_W;
          end
        end
        ST_W: begin
          if (w_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            cur_addr_reg <= cur_addr_next;
            if (last_beat) begin
              bready_reg <= 1'b1;
              state_reg  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (BVALID && bready_reg) begin
            bready_reg    <= 1'b0;
            done_reg      <= 1'b1;
            done_resp_reg <= BRESP;
            state_reg     <= ST_IDLE;
          end
        end
        ST_AR: begin
          if (arvalid_reg && ARREADY) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_R;
          end
        end
        ST_R: begin
          if (RVALID && rready_reg) begin
            rd_data_reg       <= RDATA;
            rd_data_valid_reg <= 1'b1;
            beat_cnt_reg      <= beat_cnt_reg + 8'd1;
            cur_addr_reg      <= cur_addr_next;
            // Stop at whichever comes first; a disagreement is flagged, not tolerated silently
            if (RLAST || last_beat) begin
              if (RLAST != last_beat) len_err_reg <= 1'b1;
              rready_reg    <= 1'b0;
              done_reg      <= 1'b1;
              done_resp_reg <= RRESP;
              state_reg     <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
